// File: rtl/score_pkg.sv
// Shared definitions for the score display: glyph geometry, the 8x8 digit
// font and BCD helpers.
package score_pkg;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 8;

  typedef logic [3:0] bcd_digit_t;

  // Digit font, one byte per row, bit 7 is the leftmost column; row 7 blank.
  localparam logic [7:0] GLYPH_ROM [10][8] = '{
    '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00},  // 0
    '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00},  // 1
    '{8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00},  // 2
    '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00},  // 3
    '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00},  // 4
    '{8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00},  // 5
    '{8'h3C, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00},  // 6
    '{8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00},  // 7
    '{8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00},  // 8
    '{8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h0C, 8'h38, 8'h00}   // 9
  };

  // Largest value representable with the given number of decimal digits.
  function automatic int unsigned max_value(input int unsigned digits);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < digits; i++) p = p * 10;
    return p - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to BCD converter, one bit per cycle.
// The accumulator carries one nibble more than the result so values that do
// not fit in DIGITS decimal digits saturate to all nines and raise ovf.
module bin2bcd_seq
  import score_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int VAL_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [VAL_W-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [DIGITS*4-1:0]   bcd
);

  localparam int ACC_W = (DIGITS + 1) * 4;
  localparam int CNT_W = $clog2(VAL_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic               load;
  logic [VAL_W-1:0]   sr;
  logic [ACC_W-1:0]   acc, acc_adj;
  logic               carry;
  logic               ovf_now;
  logic [CNT_W-1:0]   cnt;

  // Add 3 to every nibble that is 5 or more before the next left shift.
  function automatic logic [ACC_W-1:0] add3_all(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS + 1; i++)
      r[i*4 +: 4] = (a[i*4 +: 4] >= 4'd5) ? a[i*4 +: 4] + 4'd3 : a[i*4 +: 4];
    return r;
  endfunction

  // Clamp to all nines when the value does not fit the visible digits.
  function automatic logic [DIGITS*4-1:0] saturate_bcd(input logic [ACC_W-1:0] a,
                                                      input logic sat);
    if (sat) return {DIGITS{4'd9}};
    return a[DIGITS*4-1:0];
  endfunction

  assign acc_adj = add3_all(acc);
  assign ovf_now = carry || (acc[ACC_W-1 -: 4] != 4'd0);
  assign bcd     = saturate_bcd(acc, ovf_now);
  assign busy    = (state == SHIFT);
  assign done    = (state == DONE);

  // Next-state logic; a strobe is only accepted when not shifting.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CNT_W'(VAL_W - 1)) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: FSM, bit counter, sticky carry-out and overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        cnt   <= '0;
        carry <= 1'b0;
      end else if (state == SHIFT) begin
        cnt   <= cnt + CNT_W'(1);
        carry <= carry | acc_adj[ACC_W-1];
      end
      if (state == DONE) ovf <= ovf_now;
    end
  end

  // Shift datapath: binary bits move from sr into the BCD accumulator.
  always_ff @(posedge clk) begin
    if (load) begin
      sr  <= value;
      acc <= '0;
    end else if (state == SHIFT) begin
      acc <= {acc_adj[ACC_W-2:0], sr[VAL_W-1]};
      sr  <= sr << 1;
    end
  end

endmodule

// File: rtl/score_display.sv
// Multi-digit decimal score renderer: converts a binary value to BCD, holds it
// frame-synchronously and emits a registered 1-bit glyph pixel.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module score_display
  import score_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int VAL_W      = 14,
  parameter int SCALE_LOG2 = 0,
  parameter int COORD_W    = 10
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [VAL_W-1:0]   value_i,
  input  logic               value_vld_i,
  output logic               busy_o,
  output logic               ovf_o,
  input  logic               frame_start_i,
  input  logic [COORD_W-1:0] origin_x_i,
  input  logic [COORD_W-1:0] origin_y_i,
  input  logic [COORD_W-1:0] pix_x_i,
  input  logic [COORD_W-1:0] pix_y_i,
  output logic               in_box_o,
  output logic               pix_o
);

  localparam int DIG_W     = DIGITS * 4;
  localparam int CELL_LOG2 = 3 + SCALE_LOG2;
  localparam int BOX_W     = (DIGITS * GLYPH_W) << SCALE_LOG2;
  localparam int BOX_H     = GLYPH_H << SCALE_LOG2;

  logic                      conv_done;
  logic [DIG_W-1:0]          conv_bcd;
  logic [DIG_W-1:0]          pend_bcd;
  logic [DIG_W-1:0]          disp_bcd;
  logic                      pend_flag;
  logic [DIGITS-1:0]         lead_zero;

  logic signed [COORD_W:0]   dx_p0, dy_p0;
  int                        dx_int, dy_int;
  logic                      in_box_p0, blank_p0, pix_p0;
  logic [2:0]                col_p0, row_p0;
  bcd_digit_t                dig_p0;
  logic [7:0]                glyph_p0;
  logic                      in_box_p1, pix_p1;

  // Glyph row lookup; codes above 9 render blank.
  function automatic logic [7:0] glyph_row(input bcd_digit_t d, input logic [2:0] r);
    if (d > 4'd9) return 8'h00;
    return GLYPH_ROM[d][r];
  endfunction

  bin2bcd_seq #(
    .DIGITS (DIGITS),
    .VAL_W  (VAL_W)
  ) u_conv (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .start (value_vld_i),
    .value (value_i),
    .busy  (busy_o),
    .done  (conv_done),
    .ovf   (ovf_o),
    .bcd   (conv_bcd)
  );

  // Pending holds the newest result; display only changes at frame start.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pend_bcd  <= '0;
      disp_bcd  <= '0;
      pend_flag <= 1'b0;
    end else if (conv_done) begin
      pend_bcd  <= conv_bcd;
      pend_flag <= 1'b1;
    end else if (frame_start_i && pend_flag) begin
      disp_bcd  <= pend_bcd;
      pend_flag <= 1'b0;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Mark zero digits left of the first nonzero one; the last digit always shows.
  always_comb begin
    logic all_zero;
    all_zero  = 1'b1;
    lead_zero = '0;
    for (int k = 0; k < DIGITS - 1; k++) begin
      all_zero     = all_zero && (disp_bcd[(DIGITS-1-k)*4 +: 4] == 4'd0);
      lead_zero[k] = all_zero;
    end
  end
`else
  assign lead_zero = '0;
`endif

  // Stage p0: box test, digit/row/column select and glyph bit fetch.
  assign dx_p0 = $signed({1'b0, pix_x_i}) - $signed({1'b0, origin_x_i});
  assign dy_p0 = $signed({1'b0, pix_y_i}) - $signed({1'b0, origin_y_i});

  // Combinational render of the current scan position.
  always_comb begin
    dx_int    = int'(dx_p0);
    dy_int    = int'(dy_p0);
    in_box_p0 = (dx_int >= 0) && (dx_int < BOX_W) && (dy_int >= 0) && (dy_int < BOX_H);
    col_p0    = 3'(dx_int >>> SCALE_LOG2);
    row_p0    = 3'(dy_int >>> SCALE_LOG2);
    dig_p0    = '0;
    blank_p0  = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if ((dx_int >>> CELL_LOG2) == k) begin
        dig_p0   = disp_bcd[(DIGITS-1-k)*4 +: 4];
        blank_p0 = lead_zero[k];
      end
    end
    glyph_p0 = glyph_row(dig_p0, row_p0);
    pix_p0   = in_box_p0 && !blank_p0 && glyph_p0[3'd7 - col_p0];
  end

  // Stage p1: registered render outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      in_box_p1 <= 1'b0;
      pix_p1    <= 1'b0;
    end else begin
      in_box_p1 <= in_box_p0;
      pix_p1    <= pix_p0;
    end
  end

  assign in_box_o = in_box_p1;
  assign pix_o    = pix_p1;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display (DIGITS=4, VAL_W=14) with a second
// instance at SCALE_LOG2=1 for the magnified geometry checks.
module tb_score_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] value;
  logic        value_vld;
  logic        frame_start;
  logic [9:0]  ox, oy, px, py;
  logic        busy0, ovf0, in_box0, pix0;
  logic        busy1, ovf1, in_box1, pix1;

  int n_tests = 0;
  int n_fail  = 0;

  // Hand-copied font rows 0 and 3 for digits 0..9.
  localparam logic [7:0] R0 [10] = '{8'h3C, 8'h18, 8'h3C, 8'h3C, 8'h0C,
                                     8'h7E, 8'h3C, 8'h7E, 8'h3C, 8'h3C};
  localparam logic [7:0] R3 [10] = '{8'h76, 8'h18, 8'h0C, 8'h1C, 8'h6C,
                                     8'h06, 8'h66, 8'h18, 8'h3C, 8'h3E};

  always #5 clk = ~clk;

  score_display #(.DIGITS(4), .VAL_W(14), .SCALE_LOG2(0), .COORD_W(10)) dut0 (
    .sys_clk(clk), .sys_rst_n(rst_n), .value_i(value), .value_vld_i(value_vld),
    .busy_o(busy0), .ovf_o(ovf0), .frame_start_i(frame_start),
    .origin_x_i(ox), .origin_y_i(oy), .pix_x_i(px), .pix_y_i(py),
    .in_box_o(in_box0), .pix_o(pix0));

  score_display #(.DIGITS(4), .VAL_W(14), .SCALE_LOG2(1), .COORD_W(10)) dut1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .value_i(value), .value_vld_i(value_vld),
    .busy_o(busy1), .ovf_o(ovf1), .frame_start_i(frame_start),
    .origin_x_i(ox), .origin_y_i(oy), .pix_x_i(px), .pix_y_i(py),
    .in_box_o(in_box1), .pix_o(pix1));

  // Expected 32-pixel scan of one glyph row (0 or 3) for a 4-digit value.
  function automatic logic [31:0] exp_row(input int v, input int row);
    int d [4];
    logic [31:0] e;
    d[0] = (v / 1000) % 10; d[1] = (v / 100) % 10; d[2] = (v / 10) % 10; d[3] = v % 10;
    e = '0;
    for (int k = 0; k < 4; k++) e[31-8*k -: 8] = (row == 0) ? R0[d[k]] : R3[d[k]];
`ifdef LEADING_ZERO_BLANK_EN
    for (int k = 0; k < 3; k++) begin
      if (d[k] != 0) break;
      e[31-8*k -: 8] = 8'h00;
    end
`endif
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_conv(input int v);
    value     = 14'(v);
    value_vld = 1'b1;
    tick();
    value_vld = 1'b0;
  endtask

  // Count busy cycles until the converter reaches its DONE cycle (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (busy0 === 1'b1 && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Read back one glyph row of dut0 at origin (16,8).
  task automatic scan(input int row, output logic [31:0] bits);
    ox = 10'd16; oy = 10'd8;
    for (int x = 0; x < 32; x++) begin
      px = 10'(16 + x); py = 10'(8 + row);
      tick();
      bits[31-x] = pix0;
    end
  endtask

  task automatic test_reset();
    ox = 10'd16; oy = 10'd8; px = 10'd42; py = 10'd8;
    tick(); tick();
    n_tests++; if (pix0 !== 1'b0 || in_box0 !== 1'b0) begin n_fail++;
      $display("FAIL reset_hold pix=%b in_box=%b want 0/0", pix0, in_box0); end
    n_tests++; if (busy0 !== 1'b0 || ovf0 !== 1'b0) begin n_fail++;
      $display("FAIL reset_ctrl busy=%b ovf=%b want 0/0", busy0, ovf0); end
    rst_n = 1'b1;
    tick();
    n_tests++; if (pix0 !== 1'b1 || in_box0 !== 1'b1) begin n_fail++;
      $display("FAIL reset_zero_digit pix=%b in_box=%b want 1/1", pix0, in_box0); end
  endtask

  task automatic test_basic();
    int n;
    logic [31:0] got;
    start_conv(1234);
    wait_done(n);
    n_tests++; if (n != 14) begin n_fail++;
      $display("FAIL basic_busy_cycles got %0d want 14", n); end
    tick();
    n_tests++; if (ovf0 !== 1'b0) begin n_fail++;
      $display("FAIL basic_ovf got %b want 0", ovf0); end
    scan(0, got);
    n_tests++; if (got !== exp_row(0, 0)) begin n_fail++;
      $display("FAIL basic_before_frame got %h want %h", got, exp_row(0, 0)); end
    frame();
    for (int r = 0; r < 4; r += 3) begin
      scan(r, got);
      n_tests++; if (got !== exp_row(1234, r)) begin n_fail++;
        $display("FAIL basic_row%0d got %h want %h", r, got, exp_row(1234, r)); end
    end
    px = 10'd15; py = 10'd8; tick();
    n_tests++; if (in_box0 !== 1'b0) begin n_fail++;
      $display("FAIL box_left got %b want 0", in_box0); end
    px = 10'd47; py = 10'd15; tick();
    n_tests++; if (in_box0 !== 1'b1) begin n_fail++;
      $display("FAIL box_corner got %b want 1", in_box0); end
    px = 10'd48; py = 10'd8; tick();
    n_tests++; if (in_box0 !== 1'b0) begin n_fail++;
      $display("FAIL box_right got %b want 0", in_box0); end
    px = 10'd16; py = 10'd16; tick();
    n_tests++; if (in_box0 !== 1'b0) begin n_fail++;
      $display("FAIL box_bottom got %b want 0", in_box0); end
  endtask

  task automatic test_overflow();
    int n;
    logic [31:0] got;
    start_conv(12000); wait_done(n); tick();
    n_tests++; if (ovf0 !== 1'b1) begin n_fail++;
      $display("FAIL ovf_set got %b want 1", ovf0); end
    frame();
    for (int r = 0; r < 4; r += 3) begin
      scan(r, got);
      n_tests++; if (got !== exp_row(9999, r)) begin n_fail++;
        $display("FAIL ovf_row%0d got %h want %h", r, got, exp_row(9999, r)); end
    end
    start_conv(42); wait_done(n); tick();
    n_tests++; if (ovf0 !== 1'b0) begin n_fail++;
      $display("FAIL ovf_clear got %b want 0", ovf0); end
    frame();
    for (int r = 0; r < 4; r += 3) begin
      scan(r, got);
      n_tests++; if (got !== exp_row(42, r)) begin n_fail++;
        $display("FAIL v42_row%0d got %h want %h", r, got, exp_row(42, r)); end
    end
  endtask

  task automatic test_drop();
    int n;
    logic [31:0] got;
    start_conv(5);
    tick(); tick(); tick();
    start_conv(7);
    wait_done(n);
    n_tests++; if (n != 10) begin n_fail++;
      $display("FAIL drop_busy_cycles got %0d want 10", n); end
    tick(); frame();
    for (int r = 0; r < 4; r += 3) begin
      scan(r, got);
      n_tests++; if (got !== exp_row(5, r)) begin n_fail++;
        $display("FAIL drop_row%0d got %h want %h", r, got, exp_row(5, r)); end
    end
  endtask

  task automatic test_no_frame();
    int n;
    logic [31:0] got;
    start_conv(88); wait_done(n); tick();
    tick(); tick();
    scan(3, got);
    n_tests++; if (got !== exp_row(5, 3)) begin n_fail++;
      $display("FAIL noframe_hold got %h want %h", got, exp_row(5, 3)); end
    frame();
    scan(3, got);
    n_tests++; if (got !== exp_row(88, 3)) begin n_fail++;
      $display("FAIL noframe_update got %h want %h", got, exp_row(88, 3)); end
  endtask

  task automatic test_coincide();
    int n;
    logic [31:0] got;
    start_conv(63); wait_done(n);
    frame();
    scan(3, got);
    n_tests++; if (got !== exp_row(88, 3)) begin n_fail++;
      $display("FAIL coincide_hold got %h want %h", got, exp_row(88, 3)); end
    frame();
    scan(3, got);
    n_tests++; if (got !== exp_row(63, 3)) begin n_fail++;
      $display("FAIL coincide_next got %h want %h", got, exp_row(63, 3)); end
  endtask

  task automatic test_scale();
    int n;
    int xs  [9] = '{99, 164, 163, 101, 102, 103, 110, 108, 100};
    int ys  [9] = '{50, 50,  50,  51,  50,  51,  52,  52,  66};
    logic eb [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic ep [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    start_conv(7000); wait_done(n); tick(); frame();
    ox = 10'd100; oy = 10'd50;
    for (int i = 0; i < 9; i++) begin
      px = 10'(xs[i]); py = 10'(ys[i]);
      tick();
      n_tests++; if (in_box1 !== eb[i] || pix1 !== ep[i]) begin n_fail++;
        $display("FAIL scale_px(%0d,%0d) in_box=%b pix=%b want %b/%b",
                 xs[i], ys[i], in_box1, pix1, eb[i], ep[i]); end
    end
  endtask

  task automatic test_clip();
    ox = 10'd1000; oy = 10'd8;
    px = 10'd1023; py = 10'd8; tick();
    n_tests++; if (in_box0 !== 1'b1) begin n_fail++;
      $display("FAIL clip_edge got %b want 1", in_box0); end
    px = 10'd3; tick();
    n_tests++; if (in_box0 !== 1'b0) begin n_fail++;
      $display("FAIL clip_nowrap got %b want 0", in_box0); end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [31:0] got;
    start_conv(9999); wait_done(n); tick();
    ox = 10'd16; oy = 10'd8; px = 10'd17; py = 10'd8;
    tick();
    n_tests++; if (pix0 !== 1'b1) begin n_fail++;
      $display("FAIL rstmid_pre_pix got %b want 1", pix0); end
    start_conv(1111);
    tick(); tick();
    n_tests++; if (busy0 !== 1'b1) begin n_fail++;
      $display("FAIL rstmid_busy got %b want 1", busy0); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (busy0 !== 1'b0 || pix0 !== 1'b0 || in_box0 !== 1'b0) begin n_fail++;
      $display("FAIL rstmid_async busy=%b pix=%b in_box=%b want 0/0/0", busy0, pix0, in_box0); end
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    frame();
    for (int r = 0; r < 4; r += 3) begin
      scan(r, got);
      n_tests++; if (got !== exp_row(0, r)) begin n_fail++;
        $display("FAIL rstmid_row%0d got %h want %h", r, got, exp_row(0, r)); end
    end
  endtask

  initial begin
    rst_n = 1'b0; value = '0; value_vld = 1'b0; frame_start = 1'b0;
    ox = '0; oy = '0; px = '0; py = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_drop();
    test_no_frame();
    test_coincide();
    test_scale();
    test_clip();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
